// File: rtl/pkg_tpu.sv
// Shared TPU types for the load/store path: data/address words and the
// strided address generator's sequencer states.
package pkg_tpu;

   localparam int WIDTH_DATA = 32;
   localparam int WIDTH_ADDR = 32;

   typedef logic [WIDTH_DATA-1:0] data_t;
   typedef logic [WIDTH_ADDR-1:0] address_t;

   typedef enum logic [1:0] {
      AGU_IDLE  = 2'd0,
      AGU_ISSUE = 2'd1,
      AGU_DRAIN = 2'd2,
      AGU_DONE  = 2'd3
   } agu_state_t;

endpackage

// File: rtl/RingBuff.sv
// Generic FIFO ring buffer with a combinational head; pushes into a full
// buffer and pops from an empty one are ignored.
module RingBuff #(
   parameter int  NUM_ENTRY   = 8,
   parameter type TYPE        = logic [31:0],
   parameter int  WIDTH_ENTRY = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
)(
   input  logic clock,
   input  logic reset,
   input  logic I_We,
   input  logic I_Re,
   input  TYPE  I_Data,
   output TYPE  O_Data,
   output logic O_Empty
);

   localparam logic [WIDTH_ENTRY-1:0] PTR_LAST = WIDTH_ENTRY'(NUM_ENTRY - 1);
   localparam logic [WIDTH_ENTRY-1:0] PTR_ONE  = WIDTH_ENTRY'(1);
   localparam logic [WIDTH_ENTRY-1:0] PTR_ZERO = WIDTH_ENTRY'(0);
   localparam logic [WIDTH_ENTRY:0]   CNT_FULL = (WIDTH_ENTRY + 1)'(NUM_ENTRY);
   localparam logic [WIDTH_ENTRY:0]   CNT_ONE  = (WIDTH_ENTRY + 1)'(1);
   localparam logic [WIDTH_ENTRY:0]   CNT_ZERO = (WIDTH_ENTRY + 1)'(0);

   TYPE                    buff_r [NUM_ENTRY];
   logic [WIDTH_ENTRY-1:0] wr_ptr_r;
   logic [WIDTH_ENTRY-1:0] rd_ptr_r;
   logic [WIDTH_ENTRY:0]   count_r;
   logic                   we_s;
   logic                   re_s;

   assign we_s    = I_We & (count_r != CNT_FULL);
   assign re_s    = I_Re & (count_r != CNT_ZERO);
   assign O_Empty = (count_r == CNT_ZERO);
   assign O_Data  = buff_r[rd_ptr_r];

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (we_s) begin
         buff_r[wr_ptr_r] <= I_Data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (we_s) begin
            wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
         end
         if (re_s) begin
            rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
         end
         case ({we_s, re_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/ldst_addr_gen.sv
// Strided address generator: walks base, base+stride, ... for one access,
// issues one memory request per element and returns load data in order.
module ldst_addr_gen
   import pkg_tpu::*;
#(
   parameter int DEPTH_RET = 8,
   parameter int WIDTH_RET = $clog2(DEPTH_RET)
)(
   input  logic     clock,
   input  logic     reset,
   input  logic     I_Stall,
   input  logic     I_Req,
   input  logic     I_St,
   input  address_t I_Length,
   input  address_t I_Stride,
   input  address_t I_Base,
   output logic     O_Ready,
   input  data_t    I_St_Data,
   output logic     O_St_Re,
   output logic     O_Mem_Req,
   output logic     O_Mem_We,
   output address_t O_Mem_Addr,
   output data_t    O_Mem_Data,
   input  logic     I_Mem_Ack,
   input  logic     I_Mem_Valid,
   input  data_t    I_Mem_Data,
   output logic     O_Valid,
   output data_t    O_Data,
   output logic     O_Term
);

   localparam logic [WIDTH_RET:0] CREDIT_FULL = (WIDTH_RET + 1)'(DEPTH_RET);
   localparam logic [WIDTH_RET:0] CREDIT_ONE  = (WIDTH_RET + 1)'(1);
   localparam logic [WIDTH_RET:0] CREDIT_ZERO = (WIDTH_RET + 1)'(0);
   localparam address_t           ADDR_ONE    = address_t'(1);
   localparam address_t           ADDR_ZERO   = address_t'(0);
   localparam data_t              DATA_ZERO   = data_t'(0);

   agu_state_t         state_r;
   address_t           addr_r;
   address_t           stride_r;
   address_t           rem_r;
   logic               st_r;
   logic               ready_r;
   logic [WIDTH_RET:0] credit_r;

   logic  issue_s;
   logic  fire_s;
   logic  ld_fire_s;
   logic  push_s;
   logic  pop_s;
   logic  empty_s;
   data_t head_s;

   // A load may only issue while a return slot is guaranteed free.
   assign issue_s   = (state_r == AGU_ISSUE) & ~I_Stall & (rem_r != ADDR_ZERO) &
                      (st_r | (credit_r != CREDIT_ZERO));
   assign fire_s    = issue_s & I_Mem_Ack;
   assign ld_fire_s = fire_s & ~st_r;
   assign push_s    = I_Mem_Valid & (state_r != AGU_IDLE);
   assign pop_s     = ~I_Stall & ~empty_s;

   assign O_Ready    = ready_r;
   assign O_Mem_Req  = issue_s;
   assign O_Mem_We   = issue_s & st_r;
   assign O_Mem_Addr = addr_r;
   assign O_Mem_Data = (issue_s & st_r) ? I_St_Data : DATA_ZERO;
   assign O_St_Re    = fire_s & st_r;
   assign O_Valid    = pop_s;
   assign O_Data     = pop_s ? head_s : DATA_ZERO;
   assign O_Term     = (state_r == AGU_DONE) & ~I_Stall;

   // Sequencer, element address/remaining counters, return credit and ready flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= AGU_IDLE;
         addr_r   <= ADDR_ZERO;
         stride_r <= ADDR_ZERO;
         rem_r    <= ADDR_ZERO;
         st_r     <= 1'b0;
         ready_r  <= 1'b0;
         credit_r <= CREDIT_FULL;
      end else begin
         case ({ld_fire_s, pop_s})
            2'b10:   credit_r <= credit_r - CREDIT_ONE;
            2'b01:   credit_r <= credit_r + CREDIT_ONE;
            default: credit_r <= credit_r;
         endcase
         if (fire_s) begin
            addr_r <= addr_r + stride_r;
            rem_r  <= rem_r - ADDR_ONE;
         end
         case (state_r)
            AGU_IDLE: begin
               if (ready_r && I_Req && !I_Stall) begin
                  addr_r   <= I_Base;
                  stride_r <= I_Stride;
                  rem_r    <= I_Length;
                  st_r     <= I_St;
                  ready_r  <= 1'b0;
                  state_r  <= (I_Length == ADDR_ZERO) ? AGU_DONE : AGU_ISSUE;
               end else begin
                  ready_r  <= 1'b1;
               end
            end
            AGU_ISSUE: begin
               if (fire_s && (rem_r == ADDR_ONE)) begin
                  state_r <= AGU_DRAIN;
               end
            end
            AGU_DRAIN: begin
               if (!I_Stall && (st_r || (credit_r == CREDIT_FULL))) begin
                  state_r <= AGU_DONE;
               end
            end
            AGU_DONE: begin
               if (!I_Stall) begin
                  state_r <= AGU_IDLE;
                  ready_r <= 1'b1;
               end
            end
            default: begin
               state_r <= AGU_IDLE;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   RingBuff #(
      .NUM_ENTRY (DEPTH_RET),
      .TYPE      (data_t)
   ) u_ret_buff (
      .clock   (clock),
      .reset   (reset),
      .I_We    (push_s),
      .I_Re    (pop_s),
      .I_Data  (I_Mem_Data),
      .O_Data  (head_s),
      .O_Empty (empty_s)
   );

endmodule
